// File: rtl/mem_arbiter_if.sv
// Line-transaction bus between a cache-side master and a memory-side slave.
// The master drives the request fields; the slave returns an ack pulse and read data.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
) ();
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output enable, write, addr, wdata, input ack, rdata);
    modport slave  (input enable, write, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one Data_Memory port between icache refill (m0) and dcache (m1).
// Latches the winning request for the whole transaction and routes the ack back to it only.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_arbiter_if.slave        m0,
    mem_arbiter_if.slave        m1,
    mem_arbiter_if.master       mem,
    output logic [1:0]          grant_o,
    output logic                busy_o
);
    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e            state_q, state_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_m1_q, last_m1_d;  // 1: m1 was served last
    logic              pick_m1;
    logic              ack_now;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        grant_d   = grant_q;
        last_m1_d = last_m1_q;

        if (m0.enable && m1.enable) begin
            pick_m1 = FIXED_PRIO ? 1'b1 : ~last_m1_q;
        end else begin
            pick_m1 = m1.enable;
        end

        unique case (state_q)
            StIdle: begin
                if (m0.enable || m1.enable) begin
                    state_d = StBusy;
                    en_d    = 1'b1;
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    wr_d    = pick_m1 ? m1.write : m0.write;
                    addr_d  = pick_m1 ? m1.addr  : m0.addr;
                    data_d  = pick_m1 ? m1.wdata : m0.wdata;
                end
            end
            StBusy: begin
                if (mem.ack) begin
                    state_d   = StRelease;
                    en_d      = 1'b0;
                    wr_d      = 1'b0;
                    last_m1_d = grant_q[1];
                end
            end
            StRelease: begin
                // Unsampled cycle so the acked master can drop its enable.
                state_d = StIdle;
                grant_d = 2'b00;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            grant_q   <= 2'b00;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
        end
    end

    assign ack_now = (state_q == StBusy) && mem.ack;

    assign m0.ack   = ack_now && grant_q[0];
    assign m0.rdata = (ack_now && grant_q[0]) ? mem.rdata : '0;
    assign m1.ack   = ack_now && grant_q[1];
    assign m1.rdata = (ack_now && grant_q[1]) ? mem.rdata : '0;

    assign mem.enable = en_q;
    assign mem.write  = wr_q;
    assign mem.addr   = addr_q;
    assign mem.wdata  = data_q;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != StIdle);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases, then randomized traffic checked against
// a transaction-level model of arbitration order and line memory contents.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;

    logic       clk;
    logic       rst;
    logic [1:0] grant, fp_grant;
    logic       busy, fp_busy;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_m0 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_m1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_mem ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_rr (
        .clk_i(clk), .rst_i(rst), .m0(m0_bus), .m1(m1_bus), .mem(mem_bus),
        .grant_o(grant), .busy_o(busy)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_fp (
        .clk_i(clk), .rst_i(rst), .m0(fp_m0), .m1(fp_m1), .mem(fp_mem),
        .grant_o(fp_grant), .busy_o(fp_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5a5a_0000}};
    endfunction

    // Transaction-level model state for the randomized phase.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    bit            req_en [2];
    bit            req_wr [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2];
    bit            pend [2];
    bit            in_flight, last_m1, ack_drv, dev_active;
    int            cool, owner, dev_cnt;
    bit            lat_wr;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data, rdata_drv, exp_data;
    logic [1:0]    exp_grant;
    int            en_cnt;

    localparam logic [DW-1:0] PAT  = {2{128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
    localparam logic [DW-1:0] ECFA = {16{16'hecfa}};

    task automatic apply_reqs();
        m0_bus.enable = req_en[0]; m0_bus.write = req_wr[0];
        m0_bus.addr   = req_addr[0]; m0_bus.wdata = req_data[0];
        m1_bus.enable = req_en[1]; m1_bus.write = req_wr[1];
        m1_bus.addr   = req_addr[1]; m1_bus.wdata = req_data[1];
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_en[i] = 0; req_wr[i] = 0; req_addr[i] = '0; req_data[i] = '0; pend[i] = 0;
        end
        apply_reqs();
        mem_bus.ack = 1'b0; mem_bus.rdata = '0;
        fp_m0.enable = 1'b0; fp_m0.write = 1'b0; fp_m0.addr = '0; fp_m0.wdata = '0;
        fp_m1.enable = 1'b0; fp_m1.write = 1'b0; fp_m1.addr = '0; fp_m1.wdata = '0;
        fp_mem.ack = 1'b0; fp_mem.rdata = '0;
        rst = 1'b1;
        tick(); tick();

        chk("rst_mem_en", mem_bus.enable, 1'b0);
        chk("rst_mem_wr", mem_bus.write, 1'b0);
        chk("rst_mem_addr", mem_bus.addr, '0);
        chk("rst_mem_data", mem_bus.wdata, '0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m0_ack", m0_bus.ack, 1'b0);
        chk("rst_m1_data", m1_bus.rdata, '0);
        rst = 1'b0;

        // Single m0 read, memory acks in the 10th enable cycle.
        m0_bus.enable = 1'b1; m0_bus.write = 1'b0; m0_bus.addr = 32'h200;
        tick();
        chk("rd_grant", grant, 2'b01);
        chk("rd_addr", mem_bus.addr, 32'h200);
        chk("rd_wr", mem_bus.write, 1'b0);
        en_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) tick();
            if (mem_bus.enable) en_cnt++;
            if (k == 10) begin mem_bus.ack = 1'b1; mem_bus.rdata = PAT; end
            #1;
            chk("rd_m0_ack", m0_bus.ack, k == 10);
            chk("rd_m1_ack", m1_bus.ack, 1'b0);
            chk("rd_m1_data", m1_bus.rdata, '0);
        end
        chk("rd_m0_data", m0_bus.rdata, PAT);
        tick();
        mem_bus.ack = 1'b0; m0_bus.enable = 1'b0;
        chk("rd_en_cycles", 256'(en_cnt), 256'd10);
        chk("rel_mem_en", mem_bus.enable, 1'b0);
        chk("rel_grant", grant, 2'b01);
        chk("rel_busy", busy, 1'b1);
        tick();
        chk("idle_grant", grant, 2'b00);
        chk("idle_busy", busy, 1'b0);

        // Stray ack while idle.
        mem_bus.ack = 1'b1;
        #1;
        chk("stray_m0_ack", m0_bus.ack, 1'b0);
        chk("stray_m1_ack", m1_bus.ack, 1'b0);
        chk("stray_m0_data", m0_bus.rdata, '0);
        tick();
        mem_bus.ack = 1'b0;
        chk("stray_mem_en", mem_bus.enable, 1'b0);

        // Fixed priority: m1 wins ties and keeps winning while it requests.
        fp_m0.enable = 1'b1; fp_m0.addr = 32'h100;
        fp_m1.enable = 1'b1; fp_m1.addr = 32'h140;
        tick();
        chk("fp_grant1", fp_grant, 2'b10);
        chk("fp_addr1", fp_mem.addr, 32'h140);
        fp_mem.ack = 1'b1; fp_mem.rdata = ECFA;
        #1;
        chk("fp_m1_ack", fp_m1.ack, 1'b1);
        chk("fp_m0_ack", fp_m0.ack, 1'b0);
        tick();
        fp_mem.ack = 1'b0;
        tick();
        tick();
        chk("fp_grant2", fp_grant, 2'b10);
        fp_mem.ack = 1'b1;
        tick();
        fp_mem.ack = 1'b0; fp_m1.enable = 1'b0;
        tick();
        tick();
        chk("fp_grant3", fp_grant, 2'b01);
        chk("fp_addr3", fp_mem.addr, 32'h100);
        fp_m0.enable = 1'b0;

        // m1 write, address change mid-BUSY, then reset abandons it.
        m1_bus.enable = 1'b1; m1_bus.write = 1'b1; m1_bus.addr = 32'h40; m1_bus.wdata = ECFA;
        tick();
        chk("wr_grant", grant, 2'b10);
        chk("wr_mem_wr", mem_bus.write, 1'b1);
        chk("wr_data", mem_bus.wdata, ECFA);
        m1_bus.addr = 32'h400;
        tick();
        chk("hold_addr", mem_bus.addr, 32'h40);
        rst = 1'b1; m1_bus.enable = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstb_mem_en", mem_bus.enable, 1'b0);
        chk("rstb_grant", grant, 2'b00);
        chk("rstb_busy", busy, 1'b0);
        chk("rstb_m1_ack", m1_bus.ack, 1'b0);
        m0_bus.enable = 1'b1; m1_bus.enable = 1'b1;
        tick();
        chk("rr_reset_grant", grant, 2'b01);

        // Randomized traffic against the transaction model.
        rst = 1'b1;
        m0_bus.enable = 1'b0; m1_bus.enable = 1'b0;
        tick(); tick();
        rst = 1'b0;
        in_flight = 0; cool = 0; last_m1 = 1; owner = 0; ack_drv = 0; dev_active = 0;
        lat_wr = 0; lat_addr = '0; lat_data = '0;
        apply_reqs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            // Model the edge just passed.
            if (in_flight) begin
                if (ack_drv) begin
                    in_flight = 0; cool = 1; last_m1 = (owner == 1); pend[owner] = 0;
                    if (lat_wr) ref_mem[lat_addr] = lat_data;
                end
            end else if (cool > 0) begin
                cool = 0;
            end else if (req_en[0] || req_en[1]) begin
                if (req_en[0] && req_en[1]) owner = last_m1 ? 0 : 1;
                else owner = req_en[1] ? 1 : 0;
                in_flight = 1;
                lat_wr = req_wr[owner]; lat_addr = req_addr[owner]; lat_data = req_data[owner];
            end
            exp_grant = (in_flight || cool > 0) ? (owner == 1 ? 2'b10 : 2'b01) : 2'b00;
            chk("r_mem_en", mem_bus.enable, in_flight);
            chk("r_busy", busy, in_flight || cool > 0);
            chk("r_grant", grant, exp_grant);
            chk("r_mem_wr", mem_bus.write, in_flight && lat_wr);
            if (in_flight) begin
                chk("r_mem_addr", mem_bus.addr, lat_addr);
                chk("r_mem_data", mem_bus.wdata, lat_data);
            end

            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    req_en[i] = 0;
                    if ($urandom_range(0, 2) != 0) begin
                        pend[i] = 1; req_en[i] = 1; req_wr[i] = $urandom_range(0, 1) == 1;
                        req_addr[i] = 32'($urandom_range(0, 7)) << 6;
                        req_data[i] = rand_line();
                    end
                end else if (in_flight && owner == i) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_addr[i] = 32'($urandom_range(0, 15)) << 6;
                        req_data[i] = rand_line(); req_wr[i] = ~req_wr[i];
                    end
                    if ($urandom_range(0, 7) == 0) req_en[i] = 0;
                end
            end
            apply_reqs();

            // Data_Memory behaviour, driven from the DUT's memory port.
            ack_drv = 0; rdata_drv = rand_line();
            if (mem_bus.enable) begin
                if (!dev_active) begin dev_active = 1; dev_cnt = $urandom_range(0, 4); end
                if (dev_cnt == 0) begin
                    ack_drv = 1; dev_active = 0;
                    if (mem_bus.write) dev_mem[mem_bus.addr] = mem_bus.wdata;
                    else rdata_drv = dev_mem.exists(mem_bus.addr) ? dev_mem[mem_bus.addr]
                                                                  : init_line(mem_bus.addr);
                end else begin
                    dev_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                ack_drv = 1;
            end
            mem_bus.ack = ack_drv; mem_bus.rdata = rdata_drv;
            #1;
            exp_data = '0;
            if (in_flight && ack_drv) begin
                if (lat_wr) exp_data = rdata_drv;
                else exp_data = ref_mem.exists(lat_addr) ? ref_mem[lat_addr] : init_line(lat_addr);
            end
            chk("r_m0_ack", m0_bus.ack, in_flight && ack_drv && owner == 0);
            chk("r_m1_ack", m1_bus.ack, in_flight && ack_drv && owner == 1);
            chk("r_m0_data", m0_bus.rdata, owner == 0 ? exp_data : '0);
            chk("r_m1_data", m1_bus.rdata, owner == 1 ? exp_data : '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single off-chip Data_Memory port (enable/write/ack handshake, 32-bit address, 256-bit line) between the instruction-cache refill path (m0) and the dcache write-back/refill path (m1). It sits between the caches and Data_Memory inside CPU. It serialises line transactions, latches the winning request so the memory sees stable inputs, and routes the ack and read data back to the winner only.

Parameters:
ADDR_W, 32, address width of masters and memory port
DATA_W, 256, cache line width
FIXED_PRIO, 0, 0 = round-robin; 1 = m1 (dcache) always wins ties

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_enable_i  in  1  m0 request; held high until m0_ack_o
m0_write_i  in  1  m0 1=write line, 0=read line
m0_addr_i  in  ADDR_W  m0 line address
m0_data_i  in  DATA_W  m0 write data
m0_ack_o  out  1  m0 completion pulse
m0_data_o  out  DATA_W  m0 read data, valid with m0_ack_o
m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o  same as m0, for m1
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  DATA_W  to Data_Memory data_i
mem_ack_i  in  1  from Data_Memory ack_o (one-cycle pulse)
mem_data_i  in  DATA_W  from Data_Memory data_o
grant_o  out  2  one-hot owner of current transaction, 00 when idle
busy_o  out  1  high in BUSY and RELEASE

Behaviour:
- Reset (rst_i high at an edge): state IDLE; mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, grant_o, busy_o = 0; rr pointer set so m0 wins the first tie. m*_ack_o and m*_data_o read 0.
- States: IDLE, BUSY, RELEASE.
- IDLE: at each edge, sample m0_enable_i and m1_enable_i. If exactly one is high, grant it. If both are high: with FIXED_PRIO=1, grant m1; with FIXED_PRIO=0, grant the master not served last. On grant, register the winner's write/addr/data into mem_*_o, set mem_enable_o=1 and grant_o, then go to BUSY. With no request, stay in IDLE.
- BUSY: mem_*_o are held constant, so master input changes are not seen by memory. When mem_ack_i=1, drive the granted master's m*_ack_o=1 combinationally in that same cycle, with m*_data_o = mem_data_i (read data; write acks also pass mem_data_i). The other master's ack and data stay at 0. At that edge: clear mem_enable_o and mem_write_o, update the rr pointer to the served master, and go to RELEASE.
- RELEASE: one cycle with mem_enable_o=0 and grant_o still showing the last winner. No sampling, so the acked master has one cycle to drop its enable. Then go to IDLE. grant_o clears on entering IDLE.
- Latency: request seen at edge E gives mem_enable_o high from E+1. Ack is zero-latency pass-through. Back-to-back transactions from two waiting masters are separated by 2 idle-enable cycles (RELEASE, IDLE).
- mem_ack_i in IDLE or RELEASE is ignored; no m*_ack_o is produced.
- A master that drops its enable during BUSY does not abort the transaction. The latched transaction completes and its ack is still pulsed.
- A request arriving during BUSY or RELEASE waits; it is arbitrated in the next IDLE.
- Reset during BUSY abandons the transaction: no ack is issued, mem_enable_o=0 after the edge, and the rr pointer resets.
- The losing master is never starved under FIXED_PRIO=0: with both masters requesting continuously, grants strictly alternate.

Test Plan:
- Single read: m0 reads addr 0x00000200 with memory ack 10 cycles after enable -> mem_enable_o high for 10 cycles; m0_ack_o pulses 1 cycle with m0_data_o=0x0123_4567_..._7654_3210; m1_ack_o stays 0; RELEASE, then IDLE.
- Write then read-back: m1 writes 0xECFA...ECFA to 0x00000040, then m1 reads 0x00000040 -> read data equals the written value; mem_write_o=1 only during the write BUSY.
- Simultaneous requests, FIXED_PRIO=0, after reset -> m0 granted first, then m1; continuous requests alternate m0,m1,m0,m1 over 4 transactions.
- Simultaneous requests, FIXED_PRIO=1 -> m1 granted first; m0 is served only after m1 drops its enable.
- Master input change mid-BUSY: m0 addr changes from 0x0 to 0x400 after grant -> mem_addr_o stays 0x0 and returned data equals memory[0].
- Stray mem_ack_i in IDLE -> no m*_ack_o. rst_i high during BUSY -> mem_enable_o=0 and grant_o=00 next cycle, no ack.
